uart_regif_8n1: RTL and testbench
=================================

Name: uart_regif_8n1

Overview:
- Memory-mapped 8N1 UART peripheral with a simple sel/read/write register bus.
- Pairs with the SoC console UART: bench-side tester and SoC-side console both use it.
- Programmable bit-period divider, soft reset, receive enable, one-entry RX holding register, TX busy flag.

Parameters:
- DATA_W, 32, bus data width.
- ADDR_W, 3, register address width.
- DIV_W, 16, divider register width.
- DIV_RST, 16'd868, divider reset value (100 MHz / 115200).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- sel  in  1  peripheral select
- address  in  ADDR_W  register index
- write  in  1  write strobe (qualified by sel)
- read  in  1  read strobe (qualified by sel)
- data_in  in  DATA_W  write data
- data_out  out  DATA_W  registered read data
- txd  out  1  serial transmit
- rxd  in  1  serial receive
- rts  out  1  ready-to-receive to peer
- cts  in  1  peer ready-to-receive

Behaviour:
- Register map (shared package constants):
  - 0 UART_WRITE_WAIT (R): bit0 = TX busy.
  - 1 UART_DIV (R/W): clocks per bit.
  - 2 UART_DATA: W loads TX byte data_in[7:0]; R returns RX byte in [7:0].
  - 3 UART_SOFT_RESET (W): bit0.
  - 4 UART_READ_VALID (R): bit0 = RX byte pending.
  - 5 UART_RXEN (R/W): bit0.
  - Unmapped reads return 0; unmapped writes are ignored.
- Reset values: txd=1, rts=0, data_out=0, div=DIV_RST, rxen=0, soft_rst=0, rx_valid=0, tx busy=0.
- Writes take effect at the posedge where sel&write is high.
- Reads: data_out updates at the posedge where sel&read is high (1-cycle latency) and holds until the next read.
- Reading UART_DATA clears rx_valid at that edge. Read strobes held multiple cycles are idempotent.
- Effective divider = max(div,4). Bit period = effective divider clocks.
- TX FSM (IDLE, START, DATA, STOP):
  - A UART_DATA write in IDLE latches the byte and sets busy the same edge; it is ignored while busy.
  - Frame: start 0, 8 data bits LSB first, stop 1, each one bit period.
  - busy clears when the stop bit period ends.
- RX path:
  - rxd passes through a 2-flop synchronizer.
  - RX FSM (IDLE, START, DATA, STOP) is armed only when rxen=1.
  - A falling edge starts a frame. Mid-bit (div/2) re-check: high returns to IDLE (glitch).
  - Bits are sampled at each subsequent bit center.
  - Stop sampled 1: byte loads the holding register and sets rx_valid, overwriting any unread byte.
  - Stop sampled 0: frame discarded.
- If a frame completes on the same edge as a UART_DATA read, the new byte wins and rx_valid=1.
- Soft reset bit=1: both FSMs forced to IDLE, txd=1, rx_valid=0, rxen=0. div is retained. Bit=0 releases.
- Clearing rxen mid-frame aborts the RX frame.

Optional Feature:
- UART_HW_FLOWCTL_EN defined:
  - rts = rxen & ~rx_valid & ~soft_rst.
  - TX leaves IDLE only when the cts synchronizer output is 1; busy stays high while waiting.
- Undefined: rts driven 1 after reset release; cts ignored.

Decomposition:
- Package uart_regif_pkg: register index localparams, FSM state enum, UART_DIV_MIN=4.
- One sub-module, uart_bit_timer: loadable down-counter emitting full- and half-period ticks.
- The timer is instanced twice, once for TX and once for RX.

Test Plan:
- Reset check: after rst release, txd=1, data_out=0; reading UART_DIV returns 868; reading UART_READ_VALID returns 0.
- TX frame: DIV=10, write DATA=0x55.
  - WRITE_WAIT reads 1.
  - txd shows 0,1,0,1,0,1,0,1,0,1, each held 10 clocks.
  - WRITE_WAIT returns to 0 after 100 clocks.
  - A second write while busy is ignored.
- Loopback: two instances at DIV=10, rxen=1 on the receiver; send 0xA3 → receiver READ_VALID=1, DATA reads 0xA3, READ_VALID then 0.
- RX disabled: rxen=0, send 0x3C → READ_VALID stays 0. Framing error (stop=0) → READ_VALID stays 0.
- Overrun/soft reset: receive 0x11 then 0x22 unread → DATA=0x22. Then write SOFT_RESET 1,0 → READ_VALID=0, rxen=0, DIV still 10.
- Flow control (UART_HW_FLOWCTL_EN): cts=0, write DATA=0x7E → txd stays 1, WRITE_WAIT=1; cts=1 → frame starts within 3 clocks. rts drops when rx_valid=1.

Source files
------------

// File: rtl/uart_regif_pkg.sv
// Shared register map, FSM state type and divider floor for the 8N1 UART peripheral.
package uart_regif_pkg;

    localparam int unsigned UART_WRITE_WAIT = 0;
    localparam int unsigned UART_DIV        = 1;
    localparam int unsigned UART_DATA       = 2;
    localparam int unsigned UART_SOFT_RESET = 3;
    localparam int unsigned UART_READ_VALID = 4;
    localparam int unsigned UART_RXEN       = 5;

    localparam int unsigned UART_DIV_MIN    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter: o_full marks the end of each period, o_half its midpoint.
module uart_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_period,
    output logic             o_full,
    output logic             o_half
);

    logic [DIV_W-1:0] r_cnt;

    assign o_full = (r_cnt == '0);
    assign o_half = (r_cnt == ((i_period >> 1) - DIV_W'(1)));

    // Auto-reloads on every full tick so consecutive bits stay period-aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load || o_full) begin
            r_cnt <= i_period - DIV_W'(1);
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_regif_8n1.sv
// Memory-mapped 8N1 UART with programmable divider, soft reset, RX enable and one-entry RX hold.
// Define UART_HW_FLOWCTL_EN to enable rts/cts hardware flow control.
module uart_regif_8n1
    import uart_regif_pkg::*;
#(
    parameter int               DATA_W  = 32,
    parameter int               ADDR_W  = 3,
    parameter int               DIV_W   = 16,
    parameter logic [DIV_W-1:0] DIV_RST = 16'd868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              txd,
    input  logic              rxd,
    output logic              rts,
    input  logic              cts
);

    logic [DIV_W-1:0]  r_div;
    logic              r_rxen;
    logic              r_soft_rst;
    logic [DATA_W-1:0] r_data_out;
    logic              r_rts;

    uart_state_t       r_tx_state;
    logic [7:0]        r_tx_shift;
    logic [2:0]        r_tx_cnt;
    logic              r_tx_busy;
    logic              r_txd;

    logic              r_rx_meta;
    logic              r_rx_sync;
    logic              r_rx_prev;
    uart_state_t       r_rx_state;
    logic [7:0]        r_rx_shift;
    logic [2:0]        r_rx_cnt;
    logic [7:0]        r_rx_hold;
    logic              r_rx_valid;

    logic              w_wr;
    logic              w_rd;
    logic [DIV_W-1:0]  w_div_eff;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_cts_ok;
    logic              w_tx_wr;
    logic              w_tx_go;
    logic              w_tx_full;
    logic              w_tx_half_unused;
    logic              w_rx_arm;
    logic              w_rx_fall;
    logic              w_rx_load;
    logic              w_rx_full;
    logic              w_rx_half;
    logic              w_rx_done;
    logic              w_rx_clr;
    logic              w_unused;

    assign w_wr      = sel & write;
    assign w_rd      = sel & read;
    assign w_div_eff = (r_div < DIV_W'(UART_DIV_MIN)) ? DIV_W'(UART_DIV_MIN) : r_div;
    assign w_unused  = ^{data_in, w_tx_half_unused};

    assign data_out  = r_data_out;
    assign txd       = r_txd;
    assign rts       = r_rts;

    // ------------------------------------------------------------------
    // Register bus
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        case (address)
            ADDR_W'(UART_WRITE_WAIT): w_rd_data = {{(DATA_W-1){1'b0}}, r_tx_busy};
            ADDR_W'(UART_DIV):        w_rd_data = DATA_W'(r_div);
            ADDR_W'(UART_DATA):       w_rd_data = DATA_W'(r_rx_hold);
            ADDR_W'(UART_READ_VALID): w_rd_data = {{(DATA_W-1){1'b0}}, r_rx_valid};
            ADDR_W'(UART_RXEN):       w_rd_data = {{(DATA_W-1){1'b0}}, r_rxen};
            default:                  w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div      <= DIV_RST;
            r_rxen     <= 1'b0;
            r_soft_rst <= 1'b0;
            r_data_out <= '0;
        end else begin
            if (w_wr) begin
                case (address)
                    ADDR_W'(UART_DIV):        r_div      <= data_in[DIV_W-1:0];
                    ADDR_W'(UART_SOFT_RESET): r_soft_rst <= data_in[0];
                    ADDR_W'(UART_RXEN):       r_rxen     <= data_in[0];
                    default: ;
                endcase
            end
            if (r_soft_rst) begin
                r_rxen <= 1'b0;
            end
            if (w_rd) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
`ifdef UART_HW_FLOWCTL_EN
    logic r_cts_meta;
    logic r_cts_sync;

    assign w_cts_ok = r_cts_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cts_meta <= 1'b0;
            r_cts_sync <= 1'b0;
            r_rts      <= 1'b0;
        end else begin
            r_cts_meta <= cts;
            r_cts_sync <= r_cts_meta;
            r_rts      <= r_rxen & ~r_rx_valid & ~r_soft_rst;
        end
    end
`else
    logic w_cts_unused;

    assign w_cts_ok     = 1'b1;
    assign w_cts_unused = cts;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rts <= 1'b0;
        end else begin
            r_rts <= 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    assign w_tx_wr = w_wr && (address == ADDR_W'(UART_DATA)) && !r_tx_busy && !r_soft_rst;
    // Busy while still in IDLE means a latched byte is waiting for cts.
    assign w_tx_go = (r_tx_state == ST_IDLE) && (w_tx_wr || r_tx_busy) && w_cts_ok && !r_soft_rst;

    uart_bit_timer #(.DIV_W(DIV_W)) u_tx_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_tx_go),
        .i_period (w_div_eff),
        .o_full   (w_tx_full),
        .o_half   (w_tx_half_unused)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            r_tx_busy  <= 1'b0;
            r_txd      <= 1'b1;
        end else if (r_soft_rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_busy  <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    if (w_tx_wr) begin
                        r_tx_shift <= data_in[7:0];
                        r_tx_busy  <= 1'b1;
                    end
                    if (w_tx_go) begin
                        r_tx_state <= ST_START;
                        r_txd      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tx_full) begin
                        r_tx_state <= ST_DATA;
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_cnt   <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_tx_full) begin
                        if (r_tx_cnt == 3'd7) begin
                            r_tx_state <= ST_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_cnt   <= r_tx_cnt + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tx_full) begin
                        r_tx_state <= ST_IDLE;
                        r_tx_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    assign w_rx_arm  = r_rxen & ~r_soft_rst;
    assign w_rx_fall = r_rx_prev & ~r_rx_sync;
    // Restart the timer at mid start bit so later full ticks land on bit centres.
    assign w_rx_load = ((r_rx_state == ST_IDLE) && w_rx_arm && w_rx_fall) ||
                       ((r_rx_state == ST_START) && w_rx_half && !r_rx_sync);
    assign w_rx_done = w_rx_arm && (r_rx_state == ST_STOP) && w_rx_full && r_rx_sync;
    assign w_rx_clr  = w_rd && (address == ADDR_W'(UART_DATA));

    uart_bit_timer #(.DIV_W(DIV_W)) u_rx_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_rx_load),
        .i_period (w_div_eff),
        .o_full   (w_rx_full),
        .o_half   (w_rx_half)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_shift <= '0;
            r_rx_cnt   <= '0;
            r_rx_hold  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_meta <= rxd;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;

            if (!w_rx_arm) begin
                r_rx_state <= ST_IDLE;
            end else begin
                case (r_rx_state)
                    ST_IDLE: begin
                        if (w_rx_fall) begin
                            r_rx_state <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (w_rx_half) begin
                            r_rx_state <= r_rx_sync ? ST_IDLE : ST_DATA;
                            r_rx_cnt   <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (w_rx_full) begin
                            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                            r_rx_cnt   <= r_rx_cnt + 3'd1;
                            if (r_rx_cnt == 3'd7) begin
                                r_rx_state <= ST_STOP;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (w_rx_full) begin
                            r_rx_state <= ST_IDLE;
                        end
                    end
                endcase
            end

            if (w_rx_done) begin
                r_rx_hold <= r_rx_shift;
            end

            // A completing frame beats a same-edge DATA read.
            if (r_soft_rst) begin
                r_rx_valid <= 1'b0;
            end else if (w_rx_done) begin
                r_rx_valid <= 1'b1;
            end else if (w_rx_clr) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_regif_8n1.sv
// Directed bench: instance A transmits, instance B receives from A or from a bench-driven line.
module tb_uart_regif_8n1;

    localparam logic [2:0] A_WW   = 3'd0;
    localparam logic [2:0] A_DIV  = 3'd1;
    localparam logic [2:0] A_DATA = 3'd2;
    localparam logic [2:0] A_SRST = 3'd3;
    localparam logic [2:0] A_RV   = 3'd4;
    localparam logic [2:0] A_RXEN = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        a_sel = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
    logic [2:0]  a_addr = '0;
    logic [31:0] a_din = '0;
    logic [31:0] a_dout;
    logic        a_txd, a_rts;
    logic        a_cts = 1'b1;

    logic        b_sel = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
    logic [2:0]  b_addr = '0;
    logic [31:0] b_din = '0;
    logic [31:0] b_dout;
    logic        b_txd, b_rts;
    logic        b_cts = 1'b1;

    logic        loop_en = 1'b0;
    logic        tb_rxd  = 1'b1;
    logic        b_rxd;

    int          n_checks = 0;
    int          n_fail   = 0;

    assign b_rxd = loop_en ? a_txd : tb_rxd;

    always #5 clk = ~clk;

    uart_regif_8n1 u_a (
        .clk(clk), .rst(rst), .sel(a_sel), .address(a_addr), .write(a_wr), .read(a_rd),
        .data_in(a_din), .data_out(a_dout), .txd(a_txd), .rxd(b_txd), .rts(a_rts), .cts(a_cts)
    );

    uart_regif_8n1 u_b (
        .clk(clk), .rst(rst), .sel(b_sel), .address(b_addr), .write(b_wr), .read(b_rd),
        .data_in(b_din), .data_out(b_dout), .txd(b_txd), .rxd(b_rxd), .rts(b_rts), .cts(b_cts)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic drive(input int inst, input logic s, input logic w, input logic r,
                         input logic [2:0] addr, input logic [31:0] d);
        if (inst == 0) begin
            a_sel = s; a_wr = w; a_rd = r; a_addr = addr; a_din = d;
        end else begin
            b_sel = s; b_wr = w; b_rd = r; b_addr = addr; b_din = d;
        end
    endtask

    task automatic bus_wr(input int inst, input logic [2:0] addr, input logic [31:0] d);
        @(negedge clk);
        drive(inst, 1'b1, 1'b1, 1'b0, addr, d);
        @(negedge clk);
        drive(inst, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic bus_rd(input int inst, input logic [2:0] addr, output logic [31:0] q);
        @(negedge clk);
        drive(inst, 1'b1, 1'b0, 1'b1, addr, 32'd0);
        @(negedge clk);
        drive(inst, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        q = (inst == 0) ? a_dout : b_dout;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bench-driven 8N1 frame at 10 clocks per bit on B's receive line.
    task automatic send_raw(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            tb_rxd = frame[k];
            wait_clks(10);
        end
        tb_rxd = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] q;
        logic [9:0]  frame;

        // Reset
        wait_clks(4);
        rst = 1'b1;
        wait_clks(2);
        check("rst_txd", {31'd0, a_txd}, 32'd1);
        check("rst_dout", a_dout, 32'd0);
`ifdef UART_HW_FLOWCTL_EN
        check("rst_rts", {31'd0, a_rts}, 32'd0);
`else
        check("rst_rts", {31'd0, a_rts}, 32'd1);
`endif
        bus_rd(0, A_DIV, q);  check("rst_div", q, 32'd868);
        bus_rd(0, A_RV, q);   check("rst_rv", q, 32'd0);
        bus_rd(0, 3'd6, q);   check("unmapped_rd", q, 32'd0);

        // TX frame 0x55 at DIV=10; second write during the frame must be ignored
        bus_wr(0, A_DIV, 32'd10);
        bus_rd(0, A_DIV, q);  check("div_rb", q, 32'd10);
        frame = {1'b1, 8'h55, 1'b0};
        bus_wr(0, A_DATA, 32'h55);
        for (int n = 0; n <= 105; n++) begin
            if (n < 100 && (n % 10 == 0 || n % 10 == 9))
                check($sformatf("tx55_n%0d", n), {31'd0, a_txd}, {31'd0, frame[n/10]});
            case (n)
                0:   drive(0, 1'b1, 1'b0, 1'b1, A_WW, 32'd0);
                1:   begin drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0); check("ww_busy", a_dout, 32'd1); end
                3:   drive(0, 1'b1, 1'b1, 1'b0, A_DATA, 32'hFF);
                4:   drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
                98:  drive(0, 1'b1, 1'b0, 1'b1, A_WW, 32'd0);
                99:  begin drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0); check("ww_end_busy", a_dout, 32'd1); end
                100: drive(0, 1'b1, 1'b0, 1'b1, A_WW, 32'd0);
                101: begin drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0); check("ww_idle", a_dout, 32'd0); end
                105: check("tx_idle_after", {31'd0, a_txd}, 32'd1);
                default: ;
            endcase
            @(negedge clk);
        end

        // DIV below the floor behaves as 4 clocks per bit
        bus_wr(0, A_DIV, 32'd3);
        bus_wr(0, A_DATA, 32'h01);
        wait_clks(3);
        check("div3_start", {31'd0, a_txd}, 32'd0);
        wait_clks(1);
        check("div3_bit0", {31'd0, a_txd}, 32'd1);
        wait_clks(45);
        bus_wr(0, A_DIV, 32'd10);

        // Loopback A -> B
        bus_wr(1, A_DIV, 32'd10);
        bus_wr(1, A_RXEN, 32'd1);
        loop_en = 1'b1;
        wait_clks(5);
        bus_wr(0, A_DATA, 32'hA3);
        wait_clks(110);
`ifdef UART_HW_FLOWCTL_EN
        check("rts_drop", {31'd0, b_rts}, 32'd0);
`else
        check("rts_high", {31'd0, b_rts}, 32'd1);
`endif
        bus_rd(1, A_RV, q);   check("lb_rv1", q, 32'd1);
        bus_rd(1, A_DATA, q); check("lb_data", q, 32'hA3);
        bus_rd(1, A_RV, q);   check("lb_rv0", q, 32'd0);

        // Receiver disabled
        bus_wr(1, A_RXEN, 32'd0);
        bus_wr(0, A_DATA, 32'h3C);
        wait_clks(110);
        bus_rd(1, A_RV, q);   check("rxdis_rv", q, 32'd0);

        // Framing error and short glitch on a bench-driven line
        loop_en = 1'b0;
        bus_wr(1, A_RXEN, 32'd1);
        wait_clks(5);
        send_raw(8'h5A, 1'b0);
        wait_clks(20);
        bus_rd(1, A_RV, q);   check("frame_err_rv", q, 32'd0);
        tb_rxd = 1'b0;
        wait_clks(2);
        tb_rxd = 1'b1;
        wait_clks(30);
        bus_rd(1, A_RV, q);   check("glitch_rv", q, 32'd0);

        // Overrun: newest byte wins
        send_raw(8'h11, 1'b1);
        wait_clks(10);
        send_raw(8'h22, 1'b1);
        wait_clks(20);
        bus_rd(1, A_RV, q);   check("ovr_rv", q, 32'd1);
        bus_rd(1, A_DATA, q); check("ovr_data", q, 32'h22);

        // Soft reset clears pending byte and rxen, keeps divider
        send_raw(8'h44, 1'b1);
        wait_clks(20);
        bus_rd(1, A_RV, q);   check("pre_srst_rv", q, 32'd1);
        bus_wr(1, A_SRST, 32'd1);
        bus_wr(1, A_SRST, 32'd0);
        bus_rd(1, A_RV, q);   check("srst_rv", q, 32'd0);
        bus_rd(1, A_RXEN, q); check("srst_rxen", q, 32'd0);
        bus_rd(1, A_DIV, q);  check("srst_div", q, 32'd10);
        check("srst_txd", {31'd0, b_txd}, 32'd1);

`ifdef UART_HW_FLOWCTL_EN
        // TX held off by cts
        a_cts = 1'b0;
        wait_clks(4);
        bus_wr(0, A_DATA, 32'h7E);
        wait_clks(20);
        check("fc_hold_txd", {31'd0, a_txd}, 32'd1);
        bus_rd(0, A_WW, q);   check("fc_hold_ww", q, 32'd1);
        a_cts = 1'b1;
        wait_clks(3);
        check("fc_start_txd", {31'd0, a_txd}, 32'd0);
        wait_clks(110);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
